// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU codes and datapath mux selects.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // alu_op: fixed add, fixed sub, or decode from funct fields
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUREG = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALUOUT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       reg_write;
    logic       illegal;

    modport master (
        input  op, funct3, funct7, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal
    );
    modport slave (
        output op, funct3, funct7, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal
    );
endinterface

// File: rtl/multicycle_controller_alu_op_decoder.sv
// Maps the 2-bit alu_op plus funct fields to an ALU control code; also used
// by the single-cycle decode path.
module alu_op_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       op5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from addi, which never subtracts
                    3'b000:  alu_control = (funct7 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM. Define MEM_WAIT_EN to stall FETCH,
// MEMREAD and MEMWRITE until mem_ready.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    state_e     state_q, state_d;
    logic       mem_ok;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
    logic [2:0] alu_control;

`ifdef MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUREG;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                ir_write   = mem_ok;
                pc_write   = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                // branch target is formed here so BEQ only needs the compare
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                imm_src   = (bus.op == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = mem_ok;
                if (mem_ok) state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = SRCA_REG;
                alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALUOP_SUB;
                pc_write  = bus.zero;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_op_decoder u_alu_dec (
        .funct3      (bus.funct3),
        .funct7      (bus.funct7),
        .op5         (bus.op[5]),
        .alu_op      (alu_op),
        .alu_control (alu_control)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Reset gates outputs combinationally so an abandoned write dies in the same cycle
    assign bus.pc_write    = !reset && pc_write;
    assign bus.adr_src     = !reset && adr_src;
    assign bus.mem_write   = !reset && mem_write;
    assign bus.ir_write    = !reset && ir_write;
    assign bus.reg_write   = !reset && reg_write;
    assign bus.illegal     = !reset && illegal;
    assign bus.result_src  = reset ? 2'b00 : result_src;
    assign bus.alu_src_a   = reset ? 2'b00 : alu_src_a;
    assign bus.alu_src_b   = reset ? 2'b00 : alu_src_b;
    assign bus.imm_src     = reset ? 2'b00 : imm_src;
    assign bus.alu_control = reset ? 3'b000 : alu_control;
endmodule
